// File: rtl/word_adder_sched.sv
// word_adder_sched: shares one word_adder between two requesters. Arbitrates, drives the
// adder func sequence (LOAD, then ENABLE for RUN_CYCLES), waits WAIT_CYCLES for the result
// to settle, then returns the captured result on a valid/ready response channel.
// Build option: define WORD_ADDER_SCHED_RR_EN for round-robin tie-breaking; otherwise
// requester 0 has fixed priority.
module word_adder_sched #(
  parameter int unsigned WIDTH       = 9,
  parameter int unsigned RUN_CYCLES  = 1,  // 1..15
  parameter int unsigned WAIT_CYCLES = 1   // 0..15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic [1:0]       adder_func,
  output logic [WIDTH-1:0] adder_in_word,
  input  logic [WIDTH-1:0] adder_result,
  output logic             busy
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLoad = 3'd1;
  localparam logic [2:0] StRun  = 3'd2;
  localparam logic [2:0] StWait = 3'd3;
  localparam logic [2:0] StResp = 3'd4;

  localparam logic [1:0] FuncIdle   = 2'd0;
  localparam logic [1:0] FuncLoad   = 2'd1;
  localparam logic [1:0] FuncEnable = 2'd2;

  localparam logic [3:0] RunLoad  = 4'(RUN_CYCLES - 1);
  // Only used when WaitEn is set, so the underflow for WAIT_CYCLES == 0 is harmless.
  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES - 1);
  localparam bit         WaitEn   = (WAIT_CYCLES != 0);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic             id_q, id_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;
  logic             grant_id;
  logic             accept;

`ifdef WORD_ADDER_SCHED_RR_EN
  logic last_grant_q, last_grant_d;
`endif

  // Pick the requester to serve; ties go to the one not served last (RR) or to requester 0.
  always_comb begin
`ifdef WORD_ADDER_SCHED_RR_EN
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end else begin
      grant_id = ~req0_valid;
    end
`else
    grant_id = ~req0_valid;
`endif
  end

  // Accept only in IDLE and never while reset is asserted.
  always_comb begin
    accept     = (state_q == StIdle) && !rst && (req0_valid || req1_valid);
    req0_ready = accept && !grant_id;
    req1_ready = accept && grant_id;
  end

  // Next-state, operand latch, cycle counter and result capture.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
`ifdef WORD_ADDER_SCHED_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      StIdle: begin
        if (accept) begin
          op_d    = grant_id ? req1_data : req0_data;
          id_d    = grant_id;
          state_d = StLoad;
`ifdef WORD_ADDER_SCHED_RR_EN
          last_grant_d = grant_id;
`endif
        end
      end
      StLoad: begin
        state_d = StRun;
        cnt_d   = RunLoad;
      end
      StRun: begin
        if (cnt_q == 4'd0) begin
          if (WaitEn) begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end else begin
            // No settle time: sample the adder on the last ENABLE cycle.
            state_d    = StResp;
            rsp_data_d = adder_result;
            rsp_id_d   = id_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d    = StResp;
          rsp_data_d = adder_result;
          rsp_id_d   = id_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; an in-flight operation is simply dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= '0;
      id_q       <= 1'b0;
      cnt_q      <= 4'd0;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
`ifdef WORD_ADDER_SCHED_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
`ifdef WORD_ADDER_SCHED_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Adder control and response outputs decoded from state.
  always_comb begin
    adder_func = FuncIdle;
    case (state_q)
      StLoad:  adder_func = FuncLoad;
      StRun:   adder_func = FuncEnable;
      default: adder_func = FuncIdle;
    endcase
    adder_in_word = op_q;
    rsp_valid     = (state_q == StResp);
    rsp_data      = rsp_data_q;
    rsp_id        = rsp_id_q;
    busy          = (state_q != StIdle);
  end

endmodule
